// File: rtl/mmx_scoreboard.sv
// Register-dependency scoreboard for the MMX register-access stage: per-register
// pending-write counters, RAW/saturation stall, multi-port writeback retire.
module mmx_scoreboard #(
   parameter int unsigned NUM_REGS  = 8,
   parameter int unsigned REG_W     = 3,
   parameter int unsigned CNT_W     = 2,
   parameter int unsigned WB_PORTS  = 1,
   parameter int unsigned WB_BYPASS = 0,
   parameter int unsigned PERF_W    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [7:0]                mod_rm,
   input  logic [2:0]                op0,
   input  logic [REG_W-1:0]          op0_reg,
   input  logic                      op0_write,
   input  logic [2:0]                op1,
   input  logic [REG_W-1:0]          op1_reg,
   input  logic                      next_stage_ready,
   input  logic [WB_PORTS*REG_W-1:0] write_select,
   input  logic [WB_PORTS-1:0]       write_enable,
   output logic                      is_stall,
   output logic                      issue,
   output logic [NUM_REGS-1:0]       pending_mask,
   output logic [PERF_W-1:0]         stall_cycles,
   output logic                      wb_underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]    count_q [NUM_REGS];
   logic [CNT_W-1:0]    count_d [NUM_REGS];
   logic [NUM_REGS-1:0] pending_mask_q, pending_mask_d;
   logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;
   logic                wb_underflow_q, wb_underflow_d;

   logic [1:0]          wb_cnt [NUM_REGS];
   logic [NUM_REGS-1:0] sel0, sel1, reg_hit, reg_full;
   logic                src0_vld, src1_vld;
   int unsigned         src0_idx, src1_idx;
   logic                dep_hit, sat_hit, any_underflow;

   logic unused_modrm_bits;
   assign unused_modrm_bits = ^mod_rm[5:3];

   // Register-direct uses the explicit index; ModR/M rm only names a register in mod=11 form.
   function automatic int unsigned opnd_idx(input logic [2:0] kind, input logic [REG_W-1:0] idx);
      if (kind == 3'd4) return 32'(mod_rm[2:0]);
      return 32'(idx);
   endfunction

   function automatic logic opnd_vld(input logic [2:0] kind, input int unsigned idx);
      logic is_reg;
      is_reg = (kind == 3'd3) || ((kind == 3'd4) && (mod_rm[7:6] == 2'b11));
      return is_reg && (idx < NUM_REGS);
   endfunction

   always_comb begin
      src0_idx = opnd_idx(op0, op0_reg);
      src1_idx = opnd_idx(op1, op1_reg);
      src0_vld = opnd_vld(op0, src0_idx);
      src1_vld = opnd_vld(op1, src1_idx);
   end

   // Writebacks with an out-of-range index match no register and are dropped here.
   always_comb begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         wb_cnt[r] = 2'd0;
         for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (write_enable[p] && (32'(write_select[p*REG_W +: REG_W]) == r))
               wb_cnt[r] = wb_cnt[r] + 2'd1;
         end
      end
   end

   always_comb begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         sel0[r]     = src0_vld && (src0_idx == r);
         sel1[r]     = src1_vld && (src1_idx == r);
         reg_full[r] = (count_q[r] == CNT_MAX);
         reg_hit[r]  = (count_q[r] != '0) &&
                       !((WB_BYPASS != 0) && (32'(wb_cnt[r]) == 32'(count_q[r])));
      end
      dep_hit  = |(reg_hit & (sel0 | sel1));
      sat_hit  = op0_write && |(reg_full & sel0);
      is_stall = in_valid && (dep_hit || sat_hit);
      issue    = in_valid && !is_stall && next_stage_ready;
   end

   // Allocate and retire are netted per register; an over-retire clamps to zero and flags.
   always_comb begin
      any_underflow = 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         int unsigned sum;
         int unsigned dec;
         sum = 32'(count_q[r]) + 32'(issue && op0_write && sel0[r]);
         dec = 32'(wb_cnt[r]);
         if (dec > sum) begin
            count_d[r]    = '0;
            any_underflow = 1'b1;
         end else begin
            count_d[r] = CNT_W'(sum - dec);
         end
         pending_mask_d[r] = (count_d[r] != '0);
      end
      wb_underflow_d = wb_underflow_q || any_underflow;
      stall_cycles_d = stall_cycles_q;
      if (in_valid && is_stall && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) count_q[r] <= '0;
         pending_mask_q <= '0;
         stall_cycles_q <= '0;
         wb_underflow_q <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) count_q[r] <= count_d[r];
         pending_mask_q <= pending_mask_d;
         stall_cycles_q <= stall_cycles_d;
         wb_underflow_q <= wb_underflow_d;
      end
   end

   assign pending_mask = pending_mask_q;
   assign stall_cycles = stall_cycles_q;
   assign wb_underflow = wb_underflow_q;

endmodule
